// File: rtl/wb_slot_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_slot_decoder_if
// Purpose  : Bus bundle between the MGMT Wishbone port, the slot decoder and
//            the NUM_SLOTS user-project slots.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_slot_decoder_if #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_AW   = 12
);
  // Upstream Wishbone (MGMT SoC side)
  logic [31:0]             wbs_adr;
  logic [31:0]             wbs_wdata;
  logic [3:0]              wbs_sel;
  logic                    wbs_cyc;
  logic                    wbs_stb;
  logic                    wbs_we;
  logic                    wbs_ack;
  logic [31:0]             wbs_rdata;
  // Downstream slot side
  logic [NUM_SLOTS-1:0]    s_cyc;
  logic [NUM_SLOTS-1:0]    s_stb;
  logic                    s_we;
  logic [SLOT_AW-1:0]      s_adr;
  logic [31:0]             s_wdata;
  logic [3:0]              s_sel;
  logic [NUM_SLOTS-1:0]    s_ack;
  logic [NUM_SLOTS*32-1:0] s_rdata;

  // Decoder view: takes master requests and slot responses
  modport slave (
    input  wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    input  s_ack, s_rdata,
    output wbs_ack, wbs_rdata,
    output s_cyc, s_stb, s_we, s_adr, s_wdata, s_sel
  );

  // Environment view: drives master requests and slot responses
  modport master (
    output wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    output s_ack, s_rdata,
    input  wbs_ack, wbs_rdata,
    input  s_cyc, s_stb, s_we, s_adr, s_wdata, s_sel
  );
endinterface
`default_nettype wire

// File: rtl/wb_slot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : wb_slot_decoder
// Purpose  : Wishbone slave front end that decodes the address to one of
//            NUM_SLOTS user slots, forwards one registered transfer, returns
//            the slot response or ERR_DATA on miss/timeout, counts errors.
// Revision : 1.0 - initial release
// ============================================================================
module wb_slot_decoder #(
  parameter int          NUM_SLOTS = 4,
  parameter int          SLOT_AW   = 12,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  wire               wb_clk,
  input  wire               wb_rst,
  wb_slot_decoder_if.slave  bus,
  output logic              timeout_irq,
  output logic [15:0]       err_cnt
);

  localparam int c_sw = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int c_tw = $clog2(TIMEOUT);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_fwd  = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  localparam logic [NUM_SLOTS-1:0] c_one       = NUM_SLOTS'(1);
  localparam logic [c_tw-1:0]      c_tmo_last  = c_tw'(TIMEOUT - 1);
  // One past the last byte of the last slot window; 33 bits so a window
  // ending at the top of the address space cannot wrap.
  localparam logic [32:0]          c_end_addr  = {1'b0, BASE_ADDR} + (33'(NUM_SLOTS) << SLOT_AW);

  logic [1:0]           r_state;
  logic [c_sw-1:0]      r_slot;
  logic [c_tw-1:0]      r_timer;
  logic [NUM_SLOTS-1:0] r_strobe;
  logic                 r_we;
  logic [SLOT_AW-1:0]   r_adr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_sel;
  logic                 r_ack;
  logic [31:0]          r_rdata;
  logic [15:0]          r_err_cnt;

  logic                 w_req;
  logic                 w_hit;
  logic [c_sw-1:0]      w_slot;
  logic                 w_sel_ack;
  logic [31:0]          w_sel_rdata;
  logic                 w_miss;
  logic                 w_timeout;
  logic                 w_err_inc;

  assign w_req = bus.wbs_cyc & bus.wbs_stb;
  assign w_hit = (bus.wbs_adr >= BASE_ADDR) && ({1'b0, bus.wbs_adr} < c_end_addr);

  generate
    if (NUM_SLOTS > 1) begin : g_slot_multi
      assign w_slot = bus.wbs_adr[SLOT_AW +: c_sw];
    end else begin : g_slot_single
      assign w_slot = '0;
    end
  endgenerate

  // Only the latched slot's ack and data matter; other slots are ignored.
  assign w_sel_ack   = bus.s_ack[r_slot];
  assign w_sel_rdata = bus.s_rdata[32*r_slot +: 32];

  // An ack in the last allowed strobe cycle beats the timeout; abort beats both.
  assign w_miss    = (r_state == c_st_idle) && w_req && !w_hit;
  assign w_timeout = (r_state == c_st_fwd) && bus.wbs_cyc && !w_sel_ack && (r_timer == c_tmo_last);
  assign w_err_inc = w_miss | w_timeout;

  assign bus.s_cyc     = r_strobe;
  assign bus.s_stb     = r_strobe;
  assign bus.s_we      = r_we;
  assign bus.s_adr     = r_adr;
  assign bus.s_wdata   = r_wdata;
  assign bus.s_sel     = r_sel;
  assign bus.wbs_ack   = r_ack;
  assign bus.wbs_rdata = r_rdata;
  assign err_cnt       = r_err_cnt;

  // Transfer FSM: decode in IDLE, hold slot strobe in FWD, single ack in RESP.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state     <= c_st_idle;
      r_slot      <= '0;
      r_timer     <= '0;
      r_strobe    <= '0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      timeout_irq <= 1'b0;
    end else begin
      timeout_irq <= 1'b0;
      case (r_state)
        c_st_idle: begin
          r_ack   <= 1'b0;
          r_rdata <= '0;
          if (w_req) begin
            if (w_hit) begin
              r_slot   <= w_slot;
              r_we     <= bus.wbs_we;
              r_adr    <= bus.wbs_adr[SLOT_AW-1:0];
              r_wdata  <= bus.wbs_wdata;
              r_sel    <= bus.wbs_sel;
              r_strobe <= c_one << w_slot;
              r_timer  <= '0;
              r_state  <= c_st_fwd;
            end else begin
              r_rdata <= ERR_DATA;
              r_ack   <= 1'b1;
              r_state <= c_st_resp;
            end
          end
        end
        c_st_fwd: begin
          if (!bus.wbs_cyc) begin
            r_strobe <= '0;
            r_state  <= c_st_idle;
          end else if (w_sel_ack) begin
            r_strobe <= '0;
            r_rdata  <= r_we ? 32'd0 : w_sel_rdata;
            r_ack    <= 1'b1;
            r_state  <= c_st_resp;
          end else if (w_timeout) begin
            r_strobe    <= '0;
            r_rdata     <= ERR_DATA;
            r_ack       <= 1'b1;
            timeout_irq <= 1'b1;
            r_state     <= c_st_resp;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_st_resp: begin
          r_ack   <= 1'b0;
          r_rdata <= '0;
          r_state <= c_st_idle;
        end
        default: begin
          r_strobe <= '0;
          r_ack    <= 1'b0;
          r_rdata  <= '0;
          r_state  <= c_st_idle;
        end
      endcase
    end
  end

  // Error counter: decode misses plus timeouts, saturating at all-ones.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_err_cnt <= '0;
    end else if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
